// File: rtl/ti_sbox4_pipe.sv
// ti_sbox4_pipe: two-stage registered threshold-implementation S-box layer.
//   NSBOX parallel 4-bit S-boxes, each carried in three shares. Stage 1
//   applies the quadratic share functions G_i, stage 2 applies F_i. The
//   unmasked S-box is S(x) = F(G(x)).
//   G(x): y0=x1, y1=x2, y2=x3, y3=x0^x1x2
//   F(y): s0=y0^y2y3, s1=y1, s2=y2, s3=y3
//   Valid/ready elastic flow control, 2-deep. Processed-block counter blk_cnt.
//   Optional macro TI_SBOX_REMASK_EN adds port rnd and refreshes the stage-2
//   shares with fresh randomness before they are registered.
module ti_sbox4_pipe #(
    parameter int NSBOX = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NSBOX-1:0]   in_sh0,
    input  logic [4*NSBOX-1:0]   in_sh1,
    input  logic [4*NSBOX-1:0]   in_sh2,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef TI_SBOX_REMASK_EN
    input  logic [8*NSBOX-1:0]   rnd,
`endif
    output logic [4*NSBOX-1:0]   out_sh0,
    output logic [4*NSBOX-1:0]   out_sh1,
    output logic [4*NSBOX-1:0]   out_sh2,
    output logic [CNT_W-1:0]     blk_cnt,
    output logic                 busy
);

    localparam int W = 4 * NSBOX;

    // Output share i of a quadratic function only ever sees shares u=(i+1)%3
    // and v=(i+2)%3. The linear part is taken from u; each product a*b is
    // split as a_u b_u ^ a_u b_v ^ a_v b_u, which summed over the three
    // output shares covers all nine cross terms exactly once.
    function automatic logic [3:0] g_share(input logic [3:0] u, input logic [3:0] v);
        logic [3:0] y;
        y[0] = u[1];
        y[1] = u[2];
        y[2] = u[3];
        y[3] = u[0] ^ (u[1] & u[2]) ^ (u[1] & v[2]) ^ (v[1] & u[2]);
        return y;
    endfunction

    function automatic logic [3:0] f_share(input logic [3:0] u, input logic [3:0] v);
        logic [3:0] s;
        s[0] = u[0] ^ (u[2] & u[3]) ^ (u[2] & v[3]) ^ (v[2] & u[3]);
        s[1] = u[1];
        s[2] = u[2];
        s[3] = u[3];
        return s;
    endfunction

    // Control state
    logic             s1_v_q, s1_v_d;
    logic             s2_v_q, s2_v_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    // Share registers
    logic [W-1:0] s1_sh0_q, s1_sh1_q, s1_sh2_q;
    logic [W-1:0] s1_sh0_d, s1_sh1_d, s1_sh2_d;
    logic [W-1:0] s2_sh0_q, s2_sh1_q, s2_sh2_q;
    logic [W-1:0] s2_sh0_d, s2_sh1_d, s2_sh2_d;

    // Handshake terms
    logic s2_load;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    // Elastic handshake: s2 frees up when empty or draining, s1 follows.
    always_comb begin
        s2_load  = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_load;
        in_ready = !s1_v_q || s1_adv;
        in_fire  = in_valid && in_ready;
        out_fire = s2_v_q && out_ready;
    end

    // Next-state of valid bits and block counter.
    always_comb begin
        s1_v_d    = s1_v_q;
        s2_v_d    = s2_v_q;
        blk_cnt_d = blk_cnt_q;
        if (in_fire) begin
            s1_v_d = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
        if (s2_load) begin
            s2_v_d = s1_v_q;
        end
        if (out_fire) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
        end
    end

    // Stage-1 share functions G_i evaluated on the input shares.
    always_comb begin
        s1_sh0_d = '0;
        s1_sh1_d = '0;
        s1_sh2_d = '0;
        for (int k = 0; k < NSBOX; k++) begin
            s1_sh0_d[4*k +: 4] = g_share(in_sh1[4*k +: 4], in_sh2[4*k +: 4]);
            s1_sh1_d[4*k +: 4] = g_share(in_sh2[4*k +: 4], in_sh0[4*k +: 4]);
            s1_sh2_d[4*k +: 4] = g_share(in_sh0[4*k +: 4], in_sh1[4*k +: 4]);
        end
    end

    // Stage-2 share functions F_i on the stage-1 registers, with optional refresh.
    always_comb begin
        s2_sh0_d = '0;
        s2_sh1_d = '0;
        s2_sh2_d = '0;
        for (int k = 0; k < NSBOX; k++) begin
            s2_sh0_d[4*k +: 4] = f_share(s1_sh1_q[4*k +: 4], s1_sh2_q[4*k +: 4]);
            s2_sh1_d[4*k +: 4] = f_share(s1_sh2_q[4*k +: 4], s1_sh0_q[4*k +: 4]);
            s2_sh2_d[4*k +: 4] = f_share(s1_sh0_q[4*k +: 4], s1_sh1_q[4*k +: 4]);
        end
`ifdef TI_SBOX_REMASK_EN
        // r0 ^ r1 ^ (r0^r1) = 0, so the unmasked value is untouched.
        s2_sh0_d = s2_sh0_d ^ rnd[W-1:0];
        s2_sh1_d = s2_sh1_d ^ rnd[2*W-1:W];
        s2_sh2_d = s2_sh2_d ^ rnd[W-1:0] ^ rnd[2*W-1:W];
`endif
    end

    // Control registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            blk_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    // Stage-1 share registers: load only on input transfer, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sh0_q <= '0;
            s1_sh1_q <= '0;
            s1_sh2_q <= '0;
        end else if (in_fire) begin
            s1_sh0_q <= s1_sh0_d;
            s1_sh1_q <= s1_sh1_d;
            s1_sh2_q <= s1_sh2_d;
        end
    end

    // Stage-2 share registers: load only when stage 1 advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sh0_q <= '0;
            s2_sh1_q <= '0;
            s2_sh2_q <= '0;
        end else if (s1_adv) begin
            s2_sh0_q <= s2_sh0_d;
            s2_sh1_q <= s2_sh1_d;
            s2_sh2_q <= s2_sh2_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_sh0   = s2_sh0_q;
    assign out_sh1   = s2_sh1_q;
    assign out_sh2   = s2_sh2_q;
    assign blk_cnt   = blk_cnt_q;
    assign busy      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_ti_sbox4_pipe.sv
// Directed testbench for ti_sbox4_pipe (NSBOX=4, CNT_W=4).
module tb_ti_sbox4_pipe;

    localparam int NSBOX = 4;
    localparam int CNT_W = 4;
    localparam int W     = 4 * NSBOX;

    // Team S-box table, S(x) = F(G(x)), hand-evaluated for x = 0..15.
    localparam logic [3:0] SBOX [16] = '{
        4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'hA, 4'hB, 4'h3,
        4'h4, 4'hD, 4'h5, 4'hC, 4'h6, 4'hF, 4'hE, 4'h7
    };

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_sh0 = '0, in_sh1 = '0, in_sh2 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_sh0, out_sh1, out_sh2;
    logic [CNT_W-1:0] blk_cnt;
    logic             busy;
`ifdef TI_SBOX_REMASK_EN
    logic [2*W-1:0]   rnd = '0;
`endif

    ti_sbox4_pipe #(.NSBOX(NSBOX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .in_sh2    (in_sh2),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef TI_SBOX_REMASK_EN
        .rnd       (rnd),
`endif
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1),
        .out_sh2   (out_sh2),
        .blk_cnt   (blk_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    int               n_fire = 0;
    int               n_acc = 0;
    logic             acc_flag = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [W-1:0]     q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sbox_word(input logic [W-1:0] x);
        logic [W-1:0] y;
        for (int k = 0; k < NSBOX; k++) y[4*k +: 4] = SBOX[x[4*k +: 4]];
        return y;
    endfunction

    // Present an unmasked value as three random shares.
    task automatic drive(input logic [W-1:0] val);
        logic [W-1:0] r1, r2;
        r1 = W'($urandom);
        r2 = W'($urandom);
        in_sh1 = r1;
        in_sh2 = r2;
        in_sh0 = val ^ r1 ^ r2;
`ifdef TI_SBOX_REMASK_EN
        rnd = (2*W)'({$urandom, $urandom});
`endif
    endtask

    // One clock: observe handshakes just after the inputs settle, then move
    // to the next falling edge.
    task automatic tick();
        #1;
        chk("blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                chk("out_data", 32'(out_sh0 ^ out_sh1 ^ out_sh2), 32'(q.pop_front()));
            end
            exp_cnt = exp_cnt + 1'b1;
            n_fire++;
        end
        acc_flag = 1'b0;
        if (in_valid && in_ready) begin
            q.push_back(sbox_word(in_sh0 ^ in_sh1 ^ in_sh2));
            n_acc++;
            acc_flag = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < bound && (q.size() != 0 || busy); i++) tick();
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    int               f0, a0;
    logic [W-1:0]     v;
    logic [CNT_W-1:0] c0;

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_blk_cnt",   32'(blk_cnt),   32'd0);
        chk("rst_out_sh",    32'(out_sh0 | out_sh1 | out_sh2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Single all-zero block, 2-cycle latency
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive('0);
        in_sh0 = '0; in_sh1 = '0; in_sh2 = '0;
        tick();
        in_valid = 1'b0;
        chk("zero_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("zero_lat2_valid", 32'(out_valid), 32'd1);
        chk("zero_sh0", 32'(out_sh0), 32'd0);
        chk("zero_sh1", 32'(out_sh1), 32'd0);
        chk("zero_sh2", 32'(out_sh2), 32'd0);
        tick();
        chk("zero_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);

        // Exhaustive sweep: every nibble takes every value once
        f0 = n_fire;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < NSBOX; k++) v[4*k +: 4] = 4'(i + 5*k);
            drive(v);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("sweep_fires", 32'(n_fire - f0), 32'd16);
        chk("sweep_queue", 32'(q.size()), 32'd0);

        // Backpressure: only two blocks fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a0 = n_acc;
        f0 = n_fire;
        v  = 16'h1234;
        drive(v);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc_flag) begin
                v = v + 16'h1111;
                drive(v);
            end
        end
        #1;
        chk("bp_accepts", 32'(n_acc - a0), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        c0 = blk_cnt;
        drain(8);
        chk("bp_fires", 32'(n_fire - f0), 32'd2);
        chk("bp_blk_cnt", 32'(blk_cnt), 32'(c0 + 4'd2));

        // Simultaneous accept and drain with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(16'hA5F0);
        tick();
        drive(16'h0F5A);
        tick();
        out_ready = 1'b1;
        f0 = n_fire;
        for (int i = 0; i < 6; i++) begin
            drive(W'(16'h3C96 + 16'h0421 * i));
            #1;
            chk("sim_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("sim_busy", 32'(busy), 32'd1);
        end
        chk("sim_fires", 32'(n_fire - f0), 32'd6);
        drain(8);

        // Counter wrap with CNT_W=4: 17 transfers
        c0 = blk_cnt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(W'($urandom));
            tick();
        end
        drain(8);
        chk("wrap_blk_cnt", 32'(blk_cnt), 32'(c0 + 4'd1));

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(16'hBEEF);
        tick();
        drive(16'hCAFE);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_sh",    32'(out_sh0 | out_sh1 | out_sh2), 32'd0);
        chk("arst_blk_cnt",   32'(blk_cnt), 32'd0);
        chk("arst_busy",      32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = '0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(16'h9D27);
        tick();
        in_valid = 1'b0;
        chk("arst_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("arst_lat2_valid", 32'(out_valid), 32'd1);
        chk("arst_data", 32'(out_sh0 ^ out_sh1 ^ out_sh2), 32'(sbox_word(16'h9D27)));
        tick();
        chk("arst_blk_cnt_after", 32'(blk_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the design wedges somewhere unforeseen.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
